// File: rtl/sprite_animator_pkg.sv
// Shared definitions for the sprite animator: animation modes, sequencer
// states, default sheet geometry and the stage-1 range-test helper.
package sprite_animator_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_ONESHOT  = 2'd2,
        MODE_RSVD     = 2'd3
    } anim_mode_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_PLAY = 2'd1,
        SEQ_HOLD = 2'd2
    } seq_state_t;

    localparam int DEF_SHEET_W = 320;
    localparam int DEF_ADDR_W  = 17;

    // Signed 11-bit offset lies in [0, limit); negative offsets never wrap into a hit.
    function automatic logic in_range(input logic [10:0] d, input int limit);
        return (d[10] == 1'b0) && (d < 11'(limit));
    endfunction

endpackage

// File: rtl/sprite_frame_seq.sv
// Animation sequencer: frame_tick counter, loop / ping-pong / one-shot
// stepping of frame_idx and the one-shot done flag.
module sprite_frame_seq
    import sprite_animator_pkg::*;
#(
    parameter int FRAMES      = 4,
    parameter int FRAME_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic [1:0] mode,
    output logic [3:0] frame_idx,
    output logic       done
);

    localparam logic [3:0] LAST = 4'(FRAMES - 1);
    localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_TICKS - 1);

    seq_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             dir_down_r;
    logic [3:0]       frame_idx_r;
    logic             done_r;

    logic [3:0]       step_frame_s;
    logic             step_dir_down_s;
    logic             step_hold_s;

    // Next frame, direction and hold request should the current tick complete a step.
    always_comb begin
        step_frame_s    = frame_idx_r;
        step_dir_down_s = 1'b0;
        step_hold_s     = 1'b0;
        case (anim_mode_t'(mode))
            MODE_PINGPONG: begin
                if (LAST == 4'd0) begin
                    step_frame_s = 4'd0;
                end else if (!dir_down_r) begin
                    if (frame_idx_r == LAST) begin
                        step_dir_down_s = 1'b1;
                        step_frame_s    = frame_idx_r - 4'd1;
                    end else begin
                        step_frame_s    = frame_idx_r + 4'd1;
                    end
                end else begin
                    if (frame_idx_r == 4'd0) begin
                        step_frame_s    = 4'd1;
                    end else begin
                        step_dir_down_s = 1'b1;
                        step_frame_s    = frame_idx_r - 4'd1;
                    end
                end
            end
            MODE_ONESHOT: begin
                if ((frame_idx_r == LAST) || (frame_idx_r + 4'd1 == LAST)) begin
                    step_frame_s = LAST;
                    step_hold_s  = 1'b1;
                end else begin
                    step_frame_s = frame_idx_r + 4'd1;
                end
            end
            default: begin
                if (frame_idx_r == LAST) begin
                    step_frame_s = 4'd0;
                end else begin
                    step_frame_s = frame_idx_r + 4'd1;
                end
            end
        endcase
    end

    // Sequencer FSM; frame_idx only moves on a frame_tick so a video frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= SEQ_IDLE;
            cnt_r       <= '0;
            dir_down_r  <= 1'b0;
            frame_idx_r <= 4'd0;
            done_r      <= 1'b0;
        end else begin
            dir_down_r <= (mode == MODE_PINGPONG) ? dir_down_r : 1'b0;
            case (state_r)
                SEQ_IDLE: begin
                    frame_idx_r <= 4'd0;
                    done_r      <= 1'b0;
                    cnt_r       <= '0;
                    dir_down_r  <= 1'b0;
                    state_r     <= start ? SEQ_PLAY : SEQ_IDLE;
                end
                SEQ_PLAY: begin
                    if (start) begin
                        frame_idx_r <= 4'd0;
                        cnt_r       <= '0;
                        dir_down_r  <= 1'b0;
                        done_r      <= 1'b0;
                    end else if (frame_tick) begin
                        if (cnt_r == CNT_LAST) begin
                            cnt_r       <= '0;
                            frame_idx_r <= step_frame_s;
                            dir_down_r  <= step_dir_down_s;
                            if (step_hold_s) begin
                                state_r <= SEQ_HOLD;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= SEQ_PLAY;
                            end
                        end else begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end else begin
                        state_r <= SEQ_PLAY;
                    end
                end
                SEQ_HOLD: begin
                    if (start) begin
                        state_r     <= SEQ_PLAY;
                        frame_idx_r <= 4'd0;
                        done_r      <= 1'b0;
                        cnt_r       <= '0;
                        dir_down_r  <= 1'b0;
                    end else begin
                        frame_idx_r <= LAST;
                        done_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r <= SEQ_IDLE;
                end
            endcase
        end
    end

    assign frame_idx = frame_idx_r;
    assign done      = done_r;

endmodule

// File: rtl/sprite_animator.sv
// Animated sprite: beam position -> sprite-sheet address/enable via a two-stage
// registered pipeline. Define SPRITE_ANIM_MIRROR_EN for the flip_h mirror input.
module sprite_animator
    import sprite_animator_pkg::*;
#(
    parameter int WIDTH       = 21,
    parameter int HEIGHT      = 26,
    parameter int MEM_PIVOT_H = 0,
    parameter int MEM_PIVOT_V = 1,
    parameter int SHEET_W     = DEF_SHEET_W,
    parameter int FRAMES      = 4,
    parameter int FRAME_TICKS = 8,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        pivot_h,
    input  logic [9:0]        pivot_v,
    input  logic [9:0]        vga_h,
    input  logic [9:0]        vga_v,
    input  logic              frame_tick,
    input  logic              start,
    input  logic [1:0]        mode,
`ifdef SPRITE_ANIM_MIRROR_EN
    input  logic              flip_h,
`endif
    output logic [ADDR_W-1:0] addr,
    output logic              en,
    output logic [3:0]        frame_idx,
    output logic              done
);

    logic [9:0]        h_s, v_s;
    logic [10:0]       dh_s, dv_s;
    logic              hit_s;
    logic [9:0]        dh_eff_s;
    logic [31:0]       addr_sum_s;

    logic              s1_hit_r;
    logic [9:0]        s1_dh_r, s1_dv_r;
    logic [3:0]        s1_frame_r;
    logic [ADDR_W-1:0] addr_r;
    logic              en_r;

    sprite_frame_seq #(
        .FRAMES      (FRAMES),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .start      (start),
        .mode       (mode),
        .frame_idx  (frame_idx),
        .done       (done)
    );

    // Stage-1 hit test in sheet scale with signed offsets.
    always_comb begin
        h_s   = vga_h >> SCALE_SHIFT;
        v_s   = vga_v >> SCALE_SHIFT;
        dh_s  = {1'b0, h_s} - {1'b0, pivot_h};
        dv_s  = {1'b0, v_s} - {1'b0, pivot_v};
        hit_s = in_range(dh_s, WIDTH) && in_range(dv_s, HEIGHT);
`ifdef SPRITE_ANIM_MIRROR_EN
        if (flip_h) begin
            dh_eff_s = 10'(WIDTH - 1) - dh_s[9:0];
        end else begin
            dh_eff_s = dh_s[9:0];
        end
`else
        dh_eff_s = dh_s[9:0];
`endif
    end

    // Stage-1 registers; offsets zeroed on a miss, frame snapshotted with the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_hit_r   <= 1'b0;
            s1_dh_r    <= 10'd0;
            s1_dv_r    <= 10'd0;
            s1_frame_r <= 4'd0;
        end else begin
            s1_hit_r   <= hit_s;
            s1_dh_r    <= hit_s ? dh_eff_s : 10'd0;
            s1_dv_r    <= hit_s ? dv_s[9:0] : 10'd0;
            s1_frame_r <= frame_idx;
        end
    end

    // Sheet address of the pixel inside the snapshotted frame.
    always_comb begin
        addr_sum_s = 32'(MEM_PIVOT_H) + 32'(s1_frame_r) * 32'(WIDTH) + 32'(s1_dh_r)
                   + 32'(SHEET_W) * (32'(MEM_PIVOT_V) + 32'(s1_dv_r));
    end

    // Stage-2 registers; a miss presents address zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r <= '0;
            en_r   <= 1'b0;
        end else begin
            addr_r <= s1_hit_r ? ADDR_W'(addr_sum_s) : '0;
            en_r   <= s1_hit_r;
        end
    end

    assign addr = addr_r;
    assign en   = en_r;

endmodule

// File: tb/tb_sprite_animator.sv
// Directed self-checking bench for sprite_animator (FRAMES=4, FRAME_TICKS=2).
module tb_sprite_animator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pivot_h, pivot_v, vga_h, vga_v;
    logic        frame_tick, start;
    logic [1:0]  mode;
`ifdef SPRITE_ANIM_MIRROR_EN
    logic        flip_h;
`endif
    logic [16:0] addr;
    logic        en;
    logic [3:0]  frame_idx;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [3:0] pp_exp [12] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0,
                                4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0};

    always #5 clk = ~clk;

    sprite_animator #(.FRAMES(4), .FRAME_TICKS(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pivot_h    (pivot_h),
        .pivot_v    (pivot_v),
        .vga_h      (vga_h),
        .vga_v      (vga_v),
        .frame_tick (frame_tick),
        .start      (start),
        .mode       (mode),
`ifdef SPRITE_ANIM_MIRROR_EN
        .flip_h     (flip_h),
`endif
        .addr       (addr),
        .en         (en),
        .frame_idx  (frame_idx),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int ph, input int pv, input int vh, input int vv);
        pivot_h = 10'(ph);
        pivot_v = 10'(pv);
        vga_h   = 10'(vh);
        vga_v   = 10'(vv);
        step();
        step();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; pivot_h = 10'd0; pivot_v = 10'd0; vga_h = 10'd0; vga_v = 10'd0;
        frame_tick = 1'b0; start = 1'b0; mode = 2'd0;
`ifdef SPRITE_ANIM_MIRROR_EN
        flip_h = 1'b0;
`endif
        #2;
        chk("rst_addr", 32'(addr), 32'd0);
        chk("rst_en", 32'(en), 32'd0);
        chk("rst_frame", 32'(frame_idx), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // hit test and boundaries
        pix(10, 20, 20, 40);
        chk("hit_en", 32'(en), 32'd1);
        chk("hit_addr", 32'(addr), 32'd320);
        pix(10, 20, 19, 40);
        chk("left_miss_en", 32'(en), 32'd0);
        chk("left_miss_addr", 32'(addr), 32'd0);
        pix(5, 20, 0, 40);
        chk("neg_dh_miss", 32'(en), 32'd0);
        pix(10, 20, 60, 40);
        chk("right_edge_en", 32'(en), 32'd1);
        chk("right_edge_addr", 32'(addr), 32'd340);
        pix(10, 20, 62, 40);
        chk("right_miss", 32'(en), 32'd0);
        pix(10, 20, 21, 90);
        chk("bottom_edge_addr", 32'(addr), 32'd8320);
        pix(10, 20, 20, 92);
        chk("bottom_miss", 32'(en), 32'd0);

        // loop mode
        mode = 2'd0;
        pulse_start();
        chk("loop_start", 32'(frame_idx), 32'd0);
        tick();
        chk("loop_half", 32'(frame_idx), 32'd0);
        tick();
        chk("loop_f1", 32'(frame_idx), 32'd1);
        tick(); tick();
        chk("loop_f2", 32'(frame_idx), 32'd2);
        pix(10, 20, 20, 40);
        chk("loop_f2_addr", 32'(addr), 32'd362);
        tick(); tick();
        chk("loop_f3", 32'(frame_idx), 32'd3);
        tick(); tick();
        chk("loop_wrap", 32'(frame_idx), 32'd0);

        // ping-pong
        mode = 2'd1;
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            tick(); tick();
            chk($sformatf("pp_step%0d", i), 32'(frame_idx), 32'(pp_exp[i]));
        end

        // one-shot
        mode = 2'd2;
        pulse_start();
        tick(); tick(); tick(); tick(); tick(); tick();
        chk("os_frame", 32'(frame_idx), 32'd3);
        chk("os_done", 32'(done), 32'd1);
        tick(); tick(); tick(); tick();
        chk("os_hold_frame", 32'(frame_idx), 32'd3);
        chk("os_hold_done", 32'(done), 32'd1);
        pulse_start();
        chk("os_restart_done", 32'(done), 32'd0);
        chk("os_restart_frame", 32'(frame_idx), 32'd0);

        // start and frame_tick together
        mode = 2'd0;
        tick(); tick(); tick(); tick();
        chk("st_pre_f2", 32'(frame_idx), 32'd2);
        tick();
        start = 1'b1; frame_tick = 1'b1;
        step();
        start = 1'b0; frame_tick = 1'b0;
        chk("st_tick_frame", 32'(frame_idx), 32'd0);
        tick();
        chk("st_tick_cnt0", 32'(frame_idx), 32'd0);
        tick();
        chk("st_tick_cnt_f1", 32'(frame_idx), 32'd1);

        // asynchronous reset mid-play
        pix(10, 20, 20, 40);
        chk("pre_rst_en", 32'(en), 32'd1);
        chk("pre_rst_addr", 32'(addr), 32'd341);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_en", 32'(en), 32'd0);
        chk("async_rst_frame", 32'(frame_idx), 32'd0);
        step();
        rst_n = 1'b1;
        step();

`ifdef SPRITE_ANIM_MIRROR_EN
        flip_h = 1'b1;
        pix(10, 20, 20, 40);
        chk("mirror_addr", 32'(addr), 32'd340);
        flip_h = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
